// File: rtl/uart_hex_framer_if.sv
// uart_hex_framer_if: response-word handshake plus UART TX byte handshake
interface uart_hex_framer_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] resp_data;
    logic             resp_valid;
    logic             resp_ready;
    logic [7:0]       data;
    logic             valid;
    logic             busy;
    logic             frame_active;
    modport master (output resp_data, resp_valid, busy, input resp_ready, data, valid, frame_active);
    modport slave  (input resp_data, resp_valid, busy, output resp_ready, data, valid, frame_active);
endinterface

// File: rtl/uart_hex_framer.sv
// uart_hex_framer: serializes a response word as START_CHAR, uppercase hex digits, CR, LF; FRAMER_CHECKSUM_EN adds a two-digit byte-sum checksum before CR
module uart_hex_framer #(
    parameter int         WIDTH      = 16,
    parameter logic [7:0] START_CHAR = 8'h44
) (
    input logic              clk,
    input logic              rst,
    uart_hex_framer_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = N > 1 ? $clog2(N) : 1;
`ifdef FRAMER_CHECKSUM_EN
    localparam int EW = 8 * ((WIDTH + 7) / 8);
    typedef enum logic [2:0] {IDLE, START, HEX, CSUM, CR, LF} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, HEX, CR, LF} state_t;
`endif
    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gap_q;
    logic             accept, xfer;
    logic [7:0]       byte_c;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

`ifdef FRAMER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    function automatic logic [7:0] byte_sum(input logic [WIDTH-1:0] w);
        logic [EW-1:0] e;
        logic [7:0]    s;
        e = EW'(w);
        s = 8'h00;
        for (int k = 0; k < EW / 8; k++) s = s + e[8*k +: 8];
        return s;
    endfunction
`endif

    assign accept           = bus.resp_valid && bus.resp_ready;
    assign xfer             = bus.valid && !bus.busy;
    assign bus.resp_ready   = state_q == IDLE;
    assign bus.frame_active = state_q != IDLE;
    assign bus.valid        = state_q != IDLE && !gap_q;
    assign bus.data         = byte_c;

    // state, shifting word register, digit counter and post-transfer gap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            gap_q   <= xfer;
        end
    end

`ifdef FRAMER_CHECKSUM_EN
    // checksum captured alongside the word on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= 8'h00;
        else     csum_q <= csum_d;
    end

    // checksum next-state: load on accept, otherwise hold
    always_comb begin
        csum_d = accept ? byte_sum(bus.resp_data) : csum_q;
    end
`endif

    // next-state and current byte; the top nibble of word_q is always the next digit
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        byte_c  = 8'h00;
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                word_d  = bus.resp_data;
                cnt_d   = '0;
            end
            START: begin
                byte_c = START_CHAR;
                if (xfer) state_d = HEX;
            end
            HEX: begin
                byte_c = hex(word_q[WIDTH-1 -: 4]);
                if (xfer) begin
                    word_d = word_q << 4;
                    cnt_d  = cnt_q == CW'(N - 1) ? '0 : cnt_q + CW'(1);
`ifdef FRAMER_CHECKSUM_EN
                    if (cnt_q == CW'(N - 1)) state_d = CSUM;
`else
                    if (cnt_q == CW'(N - 1)) state_d = CR;
`endif
                end
            end
`ifdef FRAMER_CHECKSUM_EN
            CSUM: begin
                byte_c = hex(cnt_q[0] ? csum_q[3:0] : csum_q[7:4]);
                if (xfer) begin
                    cnt_d   = cnt_q[0] ? '0 : CW'(1);
                    state_d = cnt_q[0] ? CR : CSUM;
                end
            end
`endif
            CR: begin
                byte_c = 8'h0D;
                if (xfer) state_d = LF;
            end
            LF: begin
                byte_c = 8'h0A;
                if (xfer) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_hex_framer.sv
// tb_uart_hex_framer: randomized checks of uart_hex_framer against a text-level frame model
module tb_uart_hex_framer;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;
`ifdef FRAMER_CHECKSUM_EN
    localparam int FL = N + 5;
`else
    localparam int FL = N + 3;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_hex_framer_if #(.WIDTH(WIDTH)) bus();
    uart_hex_framer #(.WIDTH(WIDTH), .START_CHAR(8'h44)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         tests = 0, fails = 0, gap_viol = 0, stall_viol = 0;
    int         busy_len = 0, bcnt = 0, ncyc = 0, last_push = 0;
    logic       hold = 1'b0;
    logic [7:0] rxq[$];
    logic [7:0] exq[$];
    string      hexs = "0123456789ABCDEF";

    assign bus.busy = hold || bcnt != 0;

    // UART TX model: records transfers, checks gap and stall stability, then goes busy for busy_len cycles
    initial begin
        logic px, pv, pb;
        logic [7:0] pd;
        px = 1'b0; pv = 1'b0; pb = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            ncyc++;
            if (px && bus.valid) gap_viol++;
            if (pv && pb && !rst && (bus.valid !== 1'b1 || bus.data !== pd)) stall_viol++;
            pv = bus.valid; pb = bus.busy; pd = bus.data;
            px = bus.valid && !bus.busy && !rst;
            if (px) begin
                rxq.push_back(bus.data);
                last_push = ncyc;
            end
            @(posedge clk);
            #1;
            if (px) bcnt = busy_len;
            else if (bcnt > 0) bcnt--;
        end
    end

    function automatic void add_frame(input logic [WIDTH-1:0] w);
        int nib;
        exq.push_back(8'h44);
        for (int i = 0; i < N; i++) begin
            nib = int'((w >> (4 * (N - 1 - i))) % 16);
            exq.push_back(hexs[nib]);
        end
`ifdef FRAMER_CHECKSUM_EN
        begin
            int s;
            s = 0;
            for (int k = 0; k < WIDTH; k += 8) s += int'((w >> k) % 256);
            s = s % 256;
            exq.push_back(hexs[s / 16]);
            exq.push_back(hexs[s % 16]);
        end
`endif
        exq.push_back(8'h0D);
        exq.push_back(8'h0A);
    endfunction

    task automatic offer(input logic [WIDTH-1:0] w, input bit keep, output bit ok);
        bus.resp_data = w;
        bus.resp_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (bus.resp_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!keep) bus.resp_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (rxq.size() >= n) ok = 1'b1;
            else begin
                @(posedge clk);
                #2;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && bus.busy; i++) begin
            @(posedge clk);
            #1;
        end
        rxq.delete();
        exq.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        tests++; if (bus.data !== 8'h00) begin fails++; $display("FAIL reset_data got %02h want 00", bus.data); end
        tests++; if (bus.resp_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.resp_ready); end
        tests++; if (bus.frame_active !== 1'b0) begin fails++; $display("FAIL reset_active got %b want 0", bus.frame_active); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        drain();
        busy_len = 100;
        add_frame(16'h0069);
        offer(16'h0069, 1'b0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_accept got timeout want accept"); end
        @(negedge clk);
        tests++; if (bus.valid !== 1'b1 || bus.data !== 8'h44) begin fails++; $display("FAIL single_latency got valid=%b data=%02h want valid=1 data=44", bus.valid, bus.data); end
        tests++; if (bus.resp_ready !== 1'b0 || bus.frame_active !== 1'b1) begin fails++; $display("FAIL single_midframe got ready=%b active=%b want 0 1", bus.resp_ready, bus.frame_active); end
        wait_bytes(FL, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_wait got %0d bytes want %0d", rxq.size(), FL); end
        tests++; if (bus.resp_ready !== 1'b1 || bus.valid !== 1'b0) begin fails++; $display("FAIL single_ready_after got ready=%b valid=%b want 1 0", bus.resp_ready, bus.valid); end
        tests++; if (rxq.size() !== exq.size()) begin fails++; $display("FAIL single_len got %0d want %0d", rxq.size(), exq.size()); end
        foreach (exq[i]) if (i < rxq.size()) begin
            tests++; if (rxq[i] !== exq[i]) begin fails++; $display("FAIL single_byte%0d got %02h want %02h", i, rxq[i], exq[i]); end
        end
    endtask

    task automatic test_hex_edges();
        bit ok;
        drain();
        busy_len = $urandom_range(0, 3);
        add_frame(16'hA0F9);
        offer(16'hA0F9, 1'b0, ok);
        wait_bytes(FL, ok);
        tests++; if (!ok) begin fails++; $display("FAIL edges_wait got %0d bytes want %0d", rxq.size(), FL); end
        tests++; if (rxq.size() !== exq.size()) begin fails++; $display("FAIL edges_len got %0d want %0d", rxq.size(), exq.size()); end
        foreach (exq[i]) if (i < rxq.size()) begin
            tests++; if (rxq[i] !== exq[i]) begin fails++; $display("FAIL edges_byte%0d got %02h want %02h", i, rxq[i], exq[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        logic [WIDTH-1:0] w;
        drain();
        busy_len = 0;
        w = WIDTH'($urandom);
        hold = 1'b1;
        add_frame(w);
        offer(w, 1'b0, ok);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.valid !== 1'b1 || bus.data !== 8'h44) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        tests++; if (rxq.size() != 0) begin fails++; $display("FAIL bp_none got %0d bytes want 0", rxq.size()); end
        @(posedge clk);
        #1;
        hold = 1'b0;
        @(posedge clk);
        #2;
        tests++; if (rxq.size() != 1) begin fails++; $display("FAIL bp_one got %0d bytes want 1", rxq.size()); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL bp_gap got valid=%b want 0", bus.valid); end
        @(posedge clk);
        #2;
        tests++; if (bus.valid !== 1'b1) begin fails++; $display("FAIL bp_next got valid=%b want 1", bus.valid); end
        wait_bytes(FL, ok);
        tests++; if (rxq.size() !== exq.size()) begin fails++; $display("FAIL bp_len got %0d want %0d", rxq.size(), exq.size()); end
        foreach (exq[i]) if (i < rxq.size()) begin
            tests++; if (rxq[i] !== exq[i]) begin fails++; $display("FAIL bp_byte%0d got %02h want %02h", i, rxq[i], exq[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        drain();
        busy_len = 0;
        add_frame(16'h1234);
        add_frame(16'h5678);
        offer(16'h1234, 1'b1, ok);
        bus.resp_data = 16'h5678;
        offer(16'h5678, 1'b0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL b2b_accept got timeout want accept"); end
        tests++; if (rxq.size() != FL) begin fails++; $display("FAIL b2b_first_done got %0d bytes want %0d", rxq.size(), FL); end
        tests++; if (ncyc - last_push != 1) begin fails++; $display("FAIL b2b_gap got %0d cycles want 1", ncyc - last_push); end
        @(negedge clk);
        tests++; if (bus.valid !== 1'b1 || bus.data !== 8'h44) begin fails++; $display("FAIL b2b_start got valid=%b data=%02h want 1 44", bus.valid, bus.data); end
        wait_bytes(2 * FL, ok);
        tests++; if (rxq.size() !== exq.size()) begin fails++; $display("FAIL b2b_len got %0d want %0d", rxq.size(), exq.size()); end
        foreach (exq[i]) if (i < rxq.size()) begin
            tests++; if (rxq[i] !== exq[i]) begin fails++; $display("FAIL b2b_byte%0d got %02h want %02h", i, rxq[i], exq[i]); end
        end
    endtask

    task automatic test_ignored();
        bit ok;
        int bad;
        logic [WIDTH-1:0] w;
        drain();
        busy_len = 8;
        w = WIDTH'($urandom);
        add_frame(w);
        offer(w, 1'b0, ok);
        bad = 0;
        repeat (20) begin
            bus.resp_valid = 1'($urandom);
            bus.resp_data = WIDTH'($urandom);
            @(negedge clk);
            if (bus.resp_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        bus.resp_valid = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL ign_ready got %0d ready cycles want 0", bad); end
        wait_bytes(FL, ok);
        repeat (30) @(posedge clk);
        #2;
        tests++; if (bus.frame_active !== 1'b0) begin fails++; $display("FAIL ign_active got %b want 0", bus.frame_active); end
        tests++; if (rxq.size() !== exq.size()) begin fails++; $display("FAIL ign_len got %0d want %0d", rxq.size(), exq.size()); end
        foreach (exq[i]) if (i < rxq.size()) begin
            tests++; if (rxq[i] !== exq[i]) begin fails++; $display("FAIL ign_byte%0d got %02h want %02h", i, rxq[i], exq[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        drain();
        busy_len = 2;
        offer(WIDTH'($urandom), 1'b0, ok);
        wait_bytes(3, ok);
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.valid !== 1'b0 || bus.resp_ready !== 1'b1) begin fails++; $display("FAIL rstmid_async got valid=%b ready=%b want 0 1", bus.valid, bus.resp_ready); end
        tests++; if (bus.frame_active !== 1'b0 || bus.data !== 8'h00) begin fails++; $display("FAIL rstmid_out got active=%b data=%02h want 0 00", bus.frame_active, bus.data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain();
        add_frame(16'hBEEF);
        offer(16'hBEEF, 1'b0, ok);
        wait_bytes(FL, ok);
        repeat (5) @(posedge clk);
        #2;
        tests++; if (rxq.size() !== exq.size()) begin fails++; $display("FAIL rstmid_len got %0d want %0d", rxq.size(), exq.size()); end
        foreach (exq[i]) if (i < rxq.size()) begin
            tests++; if (rxq[i] !== exq[i]) begin fails++; $display("FAIL rstmid_byte%0d got %02h want %02h", i, rxq[i], exq[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [WIDTH-1:0] w;
        drain();
        for (int f = 0; f < 8; f++) begin
            busy_len = $urandom_range(0, 4);
            w = WIDTH'($urandom);
            add_frame(w);
            offer(w, 1'b0, ok);
            wait_bytes((f + 1) * FL, ok);
        end
        tests++; if (rxq.size() !== exq.size()) begin fails++; $display("FAIL rand_len got %0d want %0d", rxq.size(), exq.size()); end
        foreach (exq[i]) if (i < rxq.size()) begin
            tests++; if (rxq[i] !== exq[i]) begin fails++; $display("FAIL rand_byte%0d got %02h want %02h", i, rxq[i], exq[i]); end
        end
    endtask

    task automatic test_protocol();
        tests++; if (gap_viol != 0) begin fails++; $display("FAIL proto_gap got %0d violations want 0", gap_viol); end
        tests++; if (stall_viol != 0) begin fails++; $display("FAIL proto_stall got %0d violations want 0", stall_viol); end
    endtask

    initial begin
        bus.resp_valid = 1'b0;
        bus.resp_data = '0;
        test_reset();
        test_single();
        test_hex_edges();
        test_backpressure();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_hex_framer.md
Name: uart_hex_framer

Overview:
- Upstream feeder for the UART transmitter: accepts one binary response word and serializes it into an ASCII hex frame, one byte at a time, over the transmitter's data/valid/busy interface.
- Sits between the bus/bridge response path and the UART TX stage, so host-side readback sees text lines.
- Frame: START_CHAR, then WIDTH/4 uppercase hex digits (MSB nibble first), then 0x0D, then 0x0A.

Parameters:
- WIDTH, 16, response word width in bits; must be a multiple of 4 and at least 4; number of hex digits N = WIDTH/4.
- START_CHAR, 8'h44, first byte of every frame ('D').

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous active-high reset.
- resp_data  input  WIDTH  word to frame; sampled only on accept.
- resp_valid  input  1  upstream offers a word.
- resp_ready  output  1  high only in IDLE; accept = resp_valid && resp_ready.
- data  output  8  byte to the UART TX.
- valid  output  1  byte offered to the UART TX.
- busy  input  1  UART TX busy; a byte transfers on any cycle where valid && !busy.
- frame_active  output  1  high from the cycle after accept until the cycle after the final 0x0A transfer.

Behaviour:
- Reset (async, any state): state = IDLE, data = 8'h00, valid = 0, resp_ready = 1, frame_active = 0, word register and digit counter cleared. Reset mid-frame abandons the frame; no partial bytes resume.
- States: IDLE -> START -> HEX -> CR -> LF -> IDLE. When FRAMER_CHECKSUM_EN is defined, a CSUM state sits between HEX and CR.
- IDLE: on accept, latch resp_data, clear the digit counter, go to START. Accept latency: valid rises with data = START_CHAR in the cycle after accept.
- Byte states: hold data and valid stable until a transfer (valid && !busy).
  - The cycle after a transfer, valid = 0 for exactly one gap cycle. This lets the TX register busy.
  - valid rises again with the next byte on the following cycle.
  - valid never rises in the same cycle as a transfer.
- HEX: digit i (0..N-1) encodes nibble [WIDTH-1-4i -: 4].
  - Encoding: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase).
  - The counter advances on each transfer; after digit N-1 transfers, go to CR (or CSUM).
- CR sends 0x0D; LF sends 0x0A. After the LF transfer, return to IDLE. resp_ready rises in the cycle following the LF transfer (the gap cycle).
- busy held high indefinitely: the framer stalls with data/valid stable; there is no timeout.
- resp_valid while not in IDLE is ignored (resp_ready = 0); the word is not captured and there is no queuing.
- A new accept can occur in the first IDLE cycle, giving back-to-back frames with only the one-cycle gap between LF and the next START_CHAR.
- Byte count per frame = N + 3 (N + 5 with checksum).

Optional Feature:
- Macro: FRAMER_CHECKSUM_EN.
- Defined:
  - Adds the CSUM state, which emits two uppercase hex digits (high nibble first) of an 8-bit checksum, before CR.
  - Checksum = modulo-256 sum of the latched word's bytes. If WIDTH is not a multiple of 8, the top nibble is zero-extended into the top byte.
  - Frame length = N + 5.
- Undefined: no CSUM state or logic; frame length = N + 3.

Test Plan:
- Single frame: resp_data=16'h0069, default params, TX busy model = busy for 100 cycles after each transfer -> bytes 44 30 30 36 39 0D 0A in order; valid rises one cycle after accept; resp_ready returns high after the 0A transfer.
- Hex encoding edges: resp_data=16'hA0F9 -> 44 41 30 46 39 0D 0A (uppercase A/F, digit 0, digit 9).
- Backpressure: busy tied high for 500 cycles, then released -> data=0x44 with valid=1 held constant for all 500 cycles, exactly one transfer after release, followed by a one-cycle valid-low gap.
- Back-to-back plus ignored offer: resp_valid held high with 16'h1234 then 16'h5678 -> second word accepted only in the IDLE cycle after LF; resp_valid pulses mid-frame are not captured; output is two complete frames.
- Reset mid-frame: assert rst asynchronously (between clock edges) during the HEX state after 2 digits -> valid=0, resp_ready=1 immediately; the next frame 16'hBEEF emits a complete 44 42 45 45 46 0D 0A.
- With FRAMER_CHECKSUM_EN, resp_data=16'h1234 -> 44 31 32 33 34 34 36 0D 0A (checksum 0x12+0x34=0x46); without the macro the same input emits 7 bytes.
